// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Single-issue front end for an ALU stage.  It decodes one 16-bit instruction
// per cycle, reads operands from a 4x8 register file (with same-cycle
// writeback bypass), tracks in-flight destinations in a 4-bit pending
// scoreboard, and hands the operation to the ALU through one registered
// output stage using a valid/ready handshake.
//
// Ports
//   clk        sole clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   instruction offered
//   in_ready   instruction accepted this cycle when in_valid is also high
//   in_instr   [15:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [7:0] imm8
//   wb_en      writeback strobe from downstream
//   wb_addr    writeback register index
//   wb_data    writeback value
//   out_valid  issued operation present in the output stage
//   out_ready  ALU stage consumes the operation
//   out_op     ALU opcode
//   out_a      first operand
//   out_b      second operand (register value or imm8)
//   out_rd     destination register of the issued operation
//   illegal    one-cycle pulse after an undefined opcode is accepted
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic        wb_en,
    input  logic [1:0]  wb_addr,
    input  logic [7:0]  wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [7:0]  out_a,
    output logic [7:0]  out_b,
    output logic [1:0]  out_rd,
    output logic        illegal
);

    logic [7:0] regs [4];
    logic [3:0] pending;
    logic [3:0] pending_next;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [7:0] imm;

    assign op  = in_instr[15:12];
    assign rd  = in_instr[11:10];
    assign rs  = in_instr[9:8];
    assign rt  = in_instr[7:6];
    assign imm = in_instr[7:0];

    logic is_r;
    logic is_i;
    logic is_bad;

    // Opcode classes.  Anything not listed as NOP, I-type or undefined is
    // an R-type operation.
    always_comb begin
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_bad = 1'b0;
        case (op)
            4'h0:                         ;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: is_i   = 1'b1;
            4'h6, 4'h7, 4'hE:             is_bad = 1'b1;
            default:                      is_r   = 1'b1;
        endcase
    end

    // A writeback in the current cycle releases its register immediately,
    // so a waiting consumer can issue in the same cycle via the bypass.
    logic [3:0] wb_clear;
    logic [3:0] busy;
    logic       hazard;

    assign wb_clear = wb_en ? (4'b0001 << wb_addr) : 4'b0000;
    assign busy     = pending & ~wb_clear;

    // The rd check prevents two in-flight writers of the same register.
    assign hazard = (is_r || is_i) &&
                    (busy[rd] || busy[rs] || (is_r && busy[rt]));

    assign in_ready = rst_n && (!out_valid || out_ready) && !hazard;

    logic accept;
    logic issue;

    assign accept = in_valid && in_ready;
    assign issue  = accept && (is_r || is_i);

    logic [7:0] val_rs;
    logic [7:0] val_rt;

    assign val_rs = (wb_en && wb_addr == rs) ? wb_data : regs[rs];
    assign val_rt = (wb_en && wb_addr == rt) ? wb_data : regs[rt];

    // Set is applied after clear so a same-cycle set and clear of one bit
    // leaves it set.
    always_comb begin
        pending_next = pending & ~wb_clear;
        if (issue) begin
            pending_next[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= REG_INIT;
            end
            pending   <= 4'b0000;
            out_valid <= 1'b0;
            out_op    <= 4'h0;
            out_a     <= 8'h00;
            out_b     <= 8'h00;
            out_rd    <= 2'd0;
            illegal   <= 1'b0;
        end else begin
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
            pending <= pending_next;

            // The stage is only reloaded on issue; otherwise it holds its
            // fields and just drops valid once the ALU has taken it.
            if (issue) begin
                out_valid <= 1'b1;
                out_op    <= op;
                out_a     <= val_rs;
                out_b     <= is_r ? val_rt : imm;
                out_rd    <= rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            illegal <= accept && is_bad;
        end
    end

endmodule
